// File: rtl/cavlc_level_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : cavlc_level_seq_if
// Purpose  : Bundles the block-input handshake, encoder control/status and
//            result handshake of the CAVLC level sequencer.
// Modports : master - the sequencer (drives controls, counts and results)
//            slave  - the surrounding environment (block source, encoder,
//                     result sink)
// Revision : 1.0 - initial release
// ============================================================================
interface cavlc_level_seq_if #(
  parameter int COEFF_W = 8,
  parameter int CODE_W  = 128,
  parameter int BIT_W   = 7
);
  // Block input handshake
  logic                      blk_valid;
  logic                      blk_ready;
  logic [15:0][COEFF_W-1:0]  blk_coeff;
  // Encoder control and status
  logic                      enc_rst;
  logic                      enc_load;
  logic                      start_enc;
  logic [1:0]                trailing_ones_cnt;
  logic [4:0]                total_coeff_cnt;
  logic [15:0][COEFF_W-1:0]  level_code_list;
  logic [4:0]                level_code_cnt;
  logic [CODE_W-1:0]         levelcode_code;
  logic [BIT_W-1:0]          levelcode_bit;
  // Result handshake
  logic                      out_valid;
  logic                      out_ready;
  logic [CODE_W-1:0]         out_code;
  logic [BIT_W-1:0]          out_bit;
  logic [4:0]                out_total_coeff;
  logic [1:0]                out_t1;

  modport master (
    input  blk_valid, blk_coeff, levelcode_code, levelcode_bit, out_ready,
    output blk_ready, enc_rst, enc_load, start_enc, trailing_ones_cnt,
           total_coeff_cnt, level_code_list, level_code_cnt,
           out_valid, out_code, out_bit, out_total_coeff, out_t1
  );

  modport slave (
    output blk_valid, blk_coeff, levelcode_code, levelcode_bit, out_ready,
    input  blk_ready, enc_rst, enc_load, start_enc, trailing_ones_cnt,
           total_coeff_cnt, level_code_list, level_code_cnt,
           out_valid, out_code, out_bit, out_total_coeff, out_t1
  );
endinterface
`default_nettype wire

// File: rtl/cavlc_level_seq.sv
`default_nettype none
// ============================================================================
// Module   : cavlc_level_seq
// Purpose  : Sequences the CAVLC level-code encoder for one 4x4 block.
//            Scans the latched zig-zag coefficients from index 15 down to 0,
//            derives TotalCoeff / TrailingOnes / level list, steps the
//            encoder once per level and hands the captured bitstring out on
//            a valid/ready handshake.
// Ports    : clk        - clock
//            rst        - asynchronous reset, active-low
//            h264_reset - synchronous soft reset, active-high
//            bus        - cavlc_level_seq_if.master (block in, encoder
//                         control/status, result out)
// Revision : 1.0 - initial release
// ============================================================================
module cavlc_level_seq #(
  parameter int COEFF_W = 8,
  parameter int CODE_W  = 128,
  parameter int BIT_W   = 7
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          h264_reset,
  cavlc_level_seq_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SCAN = 3'd1,
    S_LOAD = 3'd2,
    S_ENC  = 3'd3,
    S_CAP  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                    r_state;
  logic [3:0]                r_idx;
  logic [15:0][COEFF_W-1:0]  r_coeff;
  logic [1:0]                r_t1;
  logic                      r_t1_closed;
  logic [4:0]                r_total;
  logic [4:0]                r_lvl_cnt;
  logic [15:0][COEFF_W-1:0]  r_list;
  logic [4:0]                r_step;
  logic [CODE_W-1:0]         r_out_code;
  logic [BIT_W-1:0]          r_out_bit;
  logic [4:0]                r_out_total;
  logic [1:0]                r_out_t1;

  logic [COEFF_W-1:0]        w_c;
  logic                      w_nonzero;
  logic                      w_t1_take;
  logic                      w_enc_last;

  assign w_c        = r_coeff[r_idx];
  assign w_nonzero  = (w_c != '0);
  // A +/-1 only counts as a trailing one while no larger level has been seen
  // yet in reverse-scan order and fewer than three have been collected.
  assign w_t1_take  = ((w_c == COEFF_W'(1)) || (w_c == {COEFF_W{1'b1}})) &&
                      !r_t1_closed && (r_t1 != 2'd3);
  // Counts go up to 16, so compare step+1 against the 5-bit level count.
  assign w_enc_last = ((r_step + 5'd1) == r_lvl_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_coeff     <= '0;
      r_t1        <= '0;
      r_t1_closed <= 1'b0;
      r_total     <= '0;
      r_lvl_cnt   <= '0;
      r_list      <= '0;
      r_step      <= '0;
      r_out_code  <= '0;
      r_out_bit   <= '0;
      r_out_total <= '0;
      r_out_t1    <= '0;
    end else if (h264_reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_coeff     <= '0;
      r_t1        <= '0;
      r_t1_closed <= 1'b0;
      r_total     <= '0;
      r_lvl_cnt   <= '0;
      r_list      <= '0;
      r_step      <= '0;
      r_out_code  <= '0;
      r_out_bit   <= '0;
      r_out_total <= '0;
      r_out_t1    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.blk_valid) begin
            r_coeff     <= bus.blk_coeff;
            r_t1        <= '0;
            r_t1_closed <= 1'b0;
            r_total     <= '0;
            r_lvl_cnt   <= '0;
            r_list      <= '0;
            r_idx       <= 4'd15;
            r_state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_nonzero) begin
            r_total <= r_total + 5'd1;
            if (w_t1_take) begin
              r_t1 <= r_t1 + 2'd1;
            end else begin
              r_list[r_lvl_cnt[3:0]] <= w_c;
              r_lvl_cnt              <= r_lvl_cnt + 5'd1;
              r_t1_closed            <= 1'b1;
            end
          end
          if (r_idx == 4'd0) begin
            r_state <= S_LOAD;
          end else begin
            r_idx <= r_idx - 4'd1;
          end
        end
        S_LOAD: begin
          r_step  <= '0;
          r_state <= (r_lvl_cnt != 5'd0) ? S_ENC : S_CAP;
        end
        S_ENC: begin
          r_step <= r_step + 5'd1;
          if (w_enc_last) begin
            r_state <= S_CAP;
          end
        end
        S_CAP: begin
          r_out_code  <= bus.levelcode_code;
          r_out_bit   <= bus.levelcode_bit;
          r_out_total <= r_total;
          r_out_t1    <= r_t1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Control strobes are pure decodes of registered state.
  assign bus.blk_ready         = (r_state == S_IDLE);
  assign bus.enc_rst           = (r_state == S_SCAN) && (r_idx == 4'd15);
  assign bus.enc_load          = (r_state == S_LOAD);
  assign bus.start_enc         = (r_state == S_ENC);
  assign bus.out_valid         = (r_state == S_DONE);

  assign bus.trailing_ones_cnt = r_t1;
  assign bus.total_coeff_cnt   = r_total;
  assign bus.level_code_list   = r_list;
  assign bus.level_code_cnt    = r_lvl_cnt;
  assign bus.out_code          = r_out_code;
  assign bus.out_bit           = r_out_bit;
  assign bus.out_total_coeff   = r_out_total;
  assign bus.out_t1            = r_out_t1;

endmodule
`default_nettype wire

// File: tb/tb_cavlc_level_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cavlc_level_seq
// Purpose  : Self-checking bench for cavlc_level_seq. A behavioural level
//            encoder answers the encoder controls; a scoreboard holds the
//            expected counts, list, bitstring and strobe timing per block.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cavlc_level_seq;

  typedef logic [15:0][7:0] blk_t;

  typedef struct {
    int           total;
    int           t1;
    int           cnt;
    int           bits;
    int           acc;
    blk_t         list;
    logic [127:0] code;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic h264_reset;
  always #5 clk = ~clk;

  cavlc_level_seq_if #(.COEFF_W(8), .CODE_W(128), .BIT_W(7)) bus ();

  cavlc_level_seq #(.COEFF_W(8), .CODE_W(128), .BIT_W(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .h264_reset (h264_reset),
    .bus        (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  exp_t q[$];
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic signed [127:0] got,
                           input logic signed [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // CAVLC level coding of one level: appends prefix zeros, a one, then suffix.
  function automatic void enc_level(input int lvl, input bit first_adj,
                                    inout int sl, output logic [127:0] b,
                                    output int len);
    int lc, pre, sfx, slen, al;
    lc = (lvl > 0) ? 2 * lvl - 2 : -2 * lvl - 1;
    if (first_adj) lc -= 2;
    if (sl == 0) begin
      if (lc < 14)      begin pre = lc; slen = 0;  sfx = 0;       end
      else if (lc < 30) begin pre = 14; slen = 4;  sfx = lc - 14; end
      else              begin pre = 15; slen = 12; sfx = lc - 30; end
    end else begin
      if (lc < (15 << sl)) begin pre = lc >> sl; slen = sl; sfx = lc & ((1 << sl) - 1); end
      else                 begin pre = 15; slen = 12; sfx = lc - (15 << sl); end
    end
    len = pre + 1 + slen;
    b   = (128'(1) << slen) | 128'(sfx);
    al  = (lvl < 0) ? -lvl : lvl;
    if (sl == 0) sl = 1;
    if ((al > (3 << (sl - 1))) && (sl < 6)) sl++;
  endfunction

  function automatic exp_t calc_exp(input blk_t c, input int acc);
    exp_t         e;
    int           sl, l, v;
    bit           closed;
    logic [127:0] b;
    e = '{default: 0};
    closed = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      v = int'($signed(c[i]));
      if (v != 0) begin
        e.total++;
        if ((v == 1 || v == -1) && !closed && e.t1 < 3) e.t1++;
        else begin
          e.list[e.cnt] = c[i];
          e.cnt++;
          closed = 1'b1;
        end
      end
    end
    sl = (e.total > 10 && e.t1 < 3) ? 1 : 0;
    for (int k = 0; k < e.cnt; k++) begin
      enc_level(int'($signed(e.list[k])), (k == 0) && (e.t1 < 3), sl, b, l);
      e.code = (e.code << l) | b;
      e.bits += l;
    end
    e.acc = acc;
    return e;
  endfunction

  // Behavioural level encoder driven by the sequencer's controls.
  logic [127:0] st_code;
  logic [6:0]   st_bit;
  int           st_sl, st_step, st_sl_n, st_l;
  logic [127:0] st_b;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_code <= '0; st_bit <= '0; st_sl <= 0; st_step <= 0;
    end else if (h264_reset || bus.enc_rst) begin
      st_code <= '0; st_bit <= '0; st_step <= 0;
    end else if (bus.enc_load) begin
      st_sl   <= (bus.total_coeff_cnt > 10 && bus.trailing_ones_cnt < 3) ? 1 : 0;
      st_step <= 0;
    end else if (bus.start_enc) begin
      st_sl_n = st_sl;
      enc_level(int'($signed(bus.level_code_list[st_step[3:0]])),
                (st_step == 0) && (bus.trailing_ones_cnt < 3), st_sl_n, st_b, st_l);
      st_code <= (st_code << st_l) | st_b;
      st_bit  <= st_bit + 7'(st_l);
      st_sl   <= st_sl_n;
      st_step <= st_step + 1;
    end
  end
  assign bus.levelcode_code = st_code;
  assign bus.levelcode_bit  = st_bit;

  // Output monitor: strobe timing per block, scoreboard compare on handshake.
  int m_rst_cyc = -1, m_load_cyc = -1, m_se_cnt = 0, m_se_first = -1;
  int m_vcyc = -1, m_hs_cyc = -1;
  always @(negedge clk) begin
    exp_t e;
    if (rst && !h264_reset) begin
      if (bus.enc_rst) begin
        m_rst_cyc = cyc; m_se_cnt = 0; m_se_first = -1; m_load_cyc = -1; m_vcyc = -1;
      end
      if (bus.enc_load) m_load_cyc = cyc;
      if (bus.start_enc) begin
        if (m_se_cnt == 0) m_se_first = cyc;
        m_se_cnt++;
      end
      if (bus.out_valid && m_vcyc < 0) m_vcyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        check_val("result_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check_val("out_total",      bus.out_total_coeff, e.total);
          check_val("out_t1",         bus.out_t1, e.t1);
          check_val("total_cnt",      bus.total_coeff_cnt, e.total);
          check_val("t1_cnt",         bus.trailing_ones_cnt, e.t1);
          check_val("lvl_cnt",        bus.level_code_cnt, e.cnt);
          check_val("lvl_list",       bus.level_code_list, e.list);
          check_val("out_code",       bus.out_code, e.code);
          check_val("out_bit",        bus.out_bit, e.bits);
          check_val("enc_rst_cyc",    m_rst_cyc, e.acc + 1);
          check_val("enc_load_cyc",   m_load_cyc, e.acc + 17);
          check_val("start_enc_len",  m_se_cnt, e.cnt);
          check_val("start_enc_first", m_se_first, (e.cnt > 0) ? e.acc + 18 : -1);
          check_val("valid_cyc",      m_vcyc, e.acc + 19 + e.cnt);
        end
        m_hs_cyc  = cyc;
        m_rst_cyc = -1;
        done_cnt++;
      end
    end
  end

  task automatic send_block(input blk_t c, input bit b2b);
    int n = 0;
    @(posedge clk); #1;
    bus.blk_valid = 1'b1;
    bus.blk_coeff = c;
    @(negedge clk);
    while (!bus.blk_ready && n < 300) begin @(negedge clk); n++; end
    check_val("accept", bus.blk_ready, 1);
    if (b2b) check_val("b2b_accept", cyc, m_hs_cyc + 1);
    q.push_back(calc_exp(c, cyc));
    @(posedge clk); #1;
    bus.blk_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 400) begin @(negedge clk); n++; end
    check_val("drain", done_cnt, target);
  endtask

  task automatic check_cleared(input string pfx);
    check_val({pfx, "_out_valid"}, bus.out_valid, 0);
    check_val({pfx, "_start_enc"}, bus.start_enc, 0);
    check_val({pfx, "_enc_load"},  bus.enc_load, 0);
    check_val({pfx, "_enc_rst"},   bus.enc_rst, 0);
    check_val({pfx, "_blk_ready"}, bus.blk_ready, 1);
    check_val({pfx, "_total"},     bus.total_coeff_cnt, 0);
    check_val({pfx, "_t1"},        bus.trailing_ones_cnt, 0);
    check_val({pfx, "_lvl_cnt"},   bus.level_code_cnt, 0);
    check_val({pfx, "_lvl_list"},  bus.level_code_list, 0);
    check_val({pfx, "_out_code"},  bus.out_code, 0);
    check_val({pfx, "_out_bit"},   bus.out_bit, 0);
    check_val({pfx, "_out_tc"},    bus.out_total_coeff, 0);
    check_val({pfx, "_out_t1"},    bus.out_t1, 0);
  endtask

  task automatic wait_start_enc();
    int n = 0;
    @(negedge clk);
    while (!bus.start_enc && n < 60) begin @(negedge clk); n++; end
    check_val("wait_start_enc", bus.start_enc, 1);
  endtask

  function automatic blk_t rand_blk(input int density);
    blk_t b;
    int   v;
    for (int i = 0; i < 16; i++) begin
      b[i] = 8'h00;
      if (int'($urandom_range(0, 99)) < density) begin
        v = int'($urandom_range(0, 6)) - 3;
        b[i] = 8'(v);
      end
    end
    return b;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t blk;
    int   tgt;
    int   n;
    rst = 1'b0; h264_reset = 1'b0;
    bus.blk_valid = 1'b0; bus.blk_coeff = '0; bus.out_ready = 1'b1;
    #12;
    check_cleared("por");
    @(posedge clk); #1 rst = 1'b1;

    // All-zero block
    blk = '0;
    tgt = done_cnt + 1; send_block(blk, 0); wait_done(tgt);
    // Single +2 at DC
    blk = '0; blk[0] = 8'h02;
    tgt = done_cnt + 1; send_block(blk, 0); wait_done(tgt);
    // Mixed block: 0,3,-1,0,0,-1,1,0,1,0...
    blk = '0; blk[1] = 8'h03; blk[2] = 8'hFF; blk[5] = 8'hFF; blk[6] = 8'h01; blk[8] = 8'h01;
    tgt = done_cnt + 1; send_block(blk, 0); wait_done(tgt);
    // Four +1: TrailingOnes saturates at 3
    blk = '0; blk[0] = 8'h01; blk[1] = 8'h01; blk[2] = 8'h01; blk[3] = 8'h01;
    tgt = done_cnt + 1; send_block(blk, 0); wait_done(tgt);
    // Sixteen non-trailing levels: counters reach 16
    for (int i = 0; i < 16; i++) blk[i] = 8'h02;
    tgt = done_cnt + 1; send_block(blk, 0); wait_done(tgt);
    // Extreme magnitudes take the escape code
    blk = '0; blk[0] = 8'h64; blk[3] = 8'h80;
    tgt = done_cnt + 1; send_block(blk, 0); wait_done(tgt);

    // Back-to-back random blocks with out_ready held high
    tgt = done_cnt + 6;
    for (int i = 0; i < 6; i++) send_block(rand_blk(i == 5 ? 100 : 45), i > 0);
    wait_done(tgt);

    // Downstream stall for 10 cycles in DONE
    bus.out_ready = 1'b0;
    blk = '0; blk[0] = 8'h05; blk[4] = 8'hFD; blk[7] = 8'h01;
    tgt = done_cnt + 1;
    send_block(blk, 0);
    n = 0;
    while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
    check_val("stall_valid_wait", bus.out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("stall_valid", bus.out_valid, 1);
      check_val("stall_blk_ready", bus.blk_ready, 0);
      check_val("stall_code", bus.out_code, (q.size() > 0) ? q[0].code : 128'd0);
      check_val("stall_bit", bus.out_bit, (q.size() > 0) ? q[0].bits : 0);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("release_blk_ready", bus.blk_ready, 1);
    check_val("release_valid", bus.out_valid, 0);
    wait_done(tgt);
    blk = '0; blk[2] = 8'h02; blk[9] = 8'hFF;
    tgt = done_cnt + 1; send_block(blk, 0); wait_done(tgt);

    // Asynchronous reset in the middle of ENC
    blk = '0; blk[0] = 8'h05; blk[1] = 8'h05; blk[2] = 8'h05; blk[3] = 8'h05;
    send_block(blk, 0);
    wait_start_enc();
    #1 rst = 1'b0;
    #1 check_cleared("arst");
    q.delete();
    @(posedge clk); #1 rst = 1'b1;
    blk = '0; blk[0] = 8'h02; blk[5] = 8'hFE;
    tgt = done_cnt + 1; send_block(blk, 0); wait_done(tgt);

    // Synchronous soft reset in the middle of ENC
    blk = '0; blk[0] = 8'hFB; blk[1] = 8'h04; blk[2] = 8'h03; blk[3] = 8'h06;
    send_block(blk, 0);
    wait_start_enc();
    #1 h264_reset = 1'b1;
    #1 check_val("h264_start_enc_hold", bus.start_enc, 1);
    @(posedge clk); #1;
    check_cleared("srst");
    h264_reset = 1'b0;
    q.delete();
    blk = '0; blk[1] = 8'h03; blk[2] = 8'hFF; blk[5] = 8'hFF; blk[6] = 8'h01; blk[8] = 8'h01;
    tgt = done_cnt + 1; send_block(blk, 0); wait_done(tgt);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cavlc_level_seq.md
Name: cavlc_level_seq

Overview:
Controller that sequences the CAVLC level-code encoder for one 4x4 residual block at a time.
- Accepts a block of zig-zag-ordered coefficients and scans it in reverse order.
- Derives TotalCoeff, TrailingOnes and the level list.
- Drives the encoder's enc_rst / enc_load / start_enc controls.
- Captures the packed level bitstring and hands it downstream over a valid/ready handshake.

Parameters:
COEFF_W, 8, signed coefficient and level width (two's complement)
CODE_W, 128, width of the packed level bitstring
BIT_W, 7, width of the bitstring length count

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low
h264_reset  input  1  synchronous soft reset, active-high, top priority after rst
blk_valid  input  1  coefficient block available
blk_ready  output  1  controller can accept a block
blk_coeff  input  16xCOEFF_W  coefficients, index 0 = DC/first in zig-zag order
enc_rst  output  1  one-cycle clear to encoder
enc_load  output  1  one-cycle suffixLength init strobe to encoder
start_enc  output  1  encode-step enable to encoder
trailing_ones_cnt  output  2  TrailingOnes of current block
total_coeff_cnt  output  5  TotalCoeff of current block
level_code_list  output  16xCOEFF_W  non-trailing-one levels, in reverse-scan order
level_code_cnt  output  5  number of valid entries in level_code_list
levelcode_code  input  CODE_W  encoder bitstring
levelcode_bit  input  BIT_W  encoder bit count
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_code  output  CODE_W  captured bitstring, right-aligned
out_bit  output  BIT_W  captured bit count
out_total_coeff  output  5  captured TotalCoeff
out_t1  output  2  captured TrailingOnes

Behaviour:
- States: IDLE, SCAN, LOAD, ENC, CAP, DONE. All control outputs are decoded from the registered state; no combinational path from inputs to outputs except blk_ready = (state==IDLE).
- Reset (rst low, asynchronous) or h264_reset (synchronous) forces the following, aborting any in-flight block with no partial output:
  - state = IDLE
  - all counters, lists, captured outputs = 0
  - out_valid = 0, enc_* = 0
- IDLE: on blk_valid && blk_ready, latch blk_coeff, clear counts and list, set scan idx = 15, go to SCAN.
- SCAN: 16 cycles, idx 15 down to 0, one coefficient per cycle.
  - enc_rst = 1 in the first SCAN cycle only.
  - Zero coefficient: ignored.
  - Nonzero coefficient: total_coeff_cnt += 1.
  - If |c| == 1, t1_closed == 0 and trailing_ones_cnt < 3: trailing_ones_cnt += 1.
  - Otherwise: level_code_list[level_code_cnt] = c, level_code_cnt += 1, t1_closed = 1.
  - Leaving idx 0 goes to LOAD.
- LOAD: 1 cycle, enc_load = 1, counts stable.
  - Next state is ENC if level_code_cnt > 0, else CAP.
- ENC: start_enc = 1 for exactly level_code_cnt consecutive cycles; an internal step counter compares against level_code_cnt. Then go to CAP.
- CAP: 1 cycle. Latch levelcode_code → out_code, levelcode_bit → out_bit, plus the counts. Go to DONE.
- DONE: out_valid = 1; outputs held stable while out_ready = 0. When out_ready = 1, go to IDLE and drop out_valid next cycle.
  - blk_ready stays 0 until IDLE; no overlap of blocks.
- Latency: the accept cycle is cycle 0. out_valid first asserts in cycle 19 + level_code_cnt.
- Throughput: one block per (20 + level_code_cnt) cycles with out_ready held high.
- level_code_list entries at index ≥ level_code_cnt are 0.
- Block with TotalCoeff = 16 and T1 = 0 gives level_code_cnt = 16; the 5-bit counters must not wrap.

Test Plan:
- All-zero block → total 0, t1 0, level_code_cnt 0, start_enc never asserted, enc_load pulse in cycle 17, out_valid in cycle 19 with out_bit 0, out_code 0.
- Single coeff +2 at idx 0 → total 1, t1 0, list[0] = 0x02, start_enc high 1 cycle (cycle 18), out_valid cycle 20, out_code = 1, out_bit = 1.
- Block 0,3,-1,0,0,-1,1,0,1,0… → total 5, t1 3, list = {0xFF, 0x03}, level_code_cnt 2, start_enc cycles 18–19, out_valid cycle 21.
- Four +1 at idx 0..3 → t1 capped at 3, list[0] = 0x01, total 4.
- out_ready held low 10 cycles in DONE → outputs and out_valid stable, blk_ready 0. Release → IDLE next cycle, next block accepted.
- rst low for one cycle, and separately h264_reset, mid-ENC → all outputs 0, start_enc drops immediately (rst) or next cycle (h264_reset); the following block encodes correctly from enc_rst.
